// File: rtl/bottle_fill_seq.sv
// BCD bottling sequencer: counts pills per bottle, runs a bottle-swap handshake, raises all_full at the bottle target.
// Optional TOTAL_COUNT_EN adds a saturating BCD total of accepted pills since the last start.
module bottle_fill_seq #(
  parameter int DIGITS       = 2,
  parameter int SWAP_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [4*DIGITS-1:0]   cfg_bcd,
  input  logic                  start,
  input  logic                  conti,
  input  logic                  next,
  input  logic                  pill,
  input  logic                  swap_ack,
  output logic [4*DIGITS-1:0]   pill_cnt,
  output logic [4*DIGITS-1:0]   bottle_cnt,
  output logic [4*DIGITS-1:0]   pill_max,
  output logic [4*DIGITS-1:0]   bottle_max,
  output logic                  gate_open,
  output logic                  swap_req,
  output logic                  all_full,
  output logic                  cfg_err,
  output logic                  swap_err,
`ifdef TOTAL_COUNT_EN
  output logic [8*DIGITS-1:0]   total_cnt,
`endif
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_SWAP = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [4*DIGITS-1:0] BCD_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

  state_t cur_state, nxt_state;
  logic [7:0] timer;
  logic [4*DIGITS-1:0] pill_inc, bottle_inc;
  logic cfg_ok, fill_done, timeout_hit;

  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [4*DIGITS-1:0] v);
    logic ok;
    ok = (v != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign pill_inc    = bcd_inc(pill_cnt);
  assign bottle_inc  = bcd_inc(bottle_cnt);
  assign cfg_ok      = bcd_valid(cfg_bcd);
  assign fill_done   = pill && (pill_inc == pill_max);
  assign timeout_hit = (timer == 8'(SWAP_TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) cur_state <= S_IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    gate_open = 1'b0;
    swap_req  = 1'b0;
    all_full  = 1'b0;
    case (cur_state)
      S_IDLE: if (start) nxt_state = S_FILL;
      S_FILL: begin
        gate_open = 1'b1;
        if (fill_done) nxt_state = (bottle_inc == bottle_max) ? S_DONE : S_SWAP;
      end
      S_SWAP: begin
        swap_req = 1'b1;
        if (swap_ack) nxt_state = conti ? S_FILL : S_WAIT;
      end
      S_WAIT: if (next || conti) nxt_state = S_FILL;
      S_DONE: begin
        all_full = 1'b1;
        if (start) nxt_state = S_FILL;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign state = cur_state;

  // Counters, targets and the swap watchdog; the ack always beats an expiring timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pill_cnt   <= '0;
      bottle_cnt <= '0;
      pill_max   <= BCD_ONE;
      bottle_max <= BCD_ONE;
      cfg_err    <= 1'b0;
      swap_err   <= 1'b0;
      timer      <= 8'd0;
    end else begin
      cfg_err <= 1'b0;
      case (cur_state)
        S_IDLE, S_DONE: begin
          if (cur_state == S_IDLE && cfg_we) begin
            if (!cfg_ok)      cfg_err    <= 1'b1;
            else if (cfg_sel) bottle_max <= cfg_bcd;
            else              pill_max   <= cfg_bcd;
          end
          if (start) begin
            pill_cnt   <= '0;
            bottle_cnt <= '0;
            swap_err   <= 1'b0;
          end
        end
        S_FILL: begin
          if (pill) pill_cnt <= pill_inc;
          if (fill_done) bottle_cnt <= bottle_inc;
        end
        S_SWAP: begin
          if (swap_ack) begin
            pill_cnt <= '0;
            timer    <= 8'd0;
          end else begin
            if (timer != 8'(SWAP_TIMEOUT)) timer <= timer + 8'd1;
            if (timeout_hit) swap_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TOTAL_COUNT_EN
  localparam logic [8*DIGITS-1:0] TOTAL_SAT = {(2*DIGITS){4'h9}};

  function automatic logic [8*DIGITS-1:0] bcd_inc_wide(input logic [8*DIGITS-1:0] v);
    logic [8*DIGITS-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 2*DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) total_cnt <= '0;
    else if ((cur_state == S_IDLE || cur_state == S_DONE) && start) total_cnt <= '0;
    else if (cur_state == S_FILL && pill && total_cnt != TOTAL_SAT)
      total_cnt <= bcd_inc_wide(total_cnt);
  end
`endif

endmodule
